// File: rtl/uart_framer_pkg.sv
// Shared definitions for the UART receive framer: sync byte, FSM state
// encoding, discard reason codes and the output beat payload.
package uart_framer_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_CSUM    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_UART    = 2'd3;

    // One payload beat presented on the output stream.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } out_beat_t;

    // Running checksum step (mod 256).
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return 8'(acc + b);
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM, synchronous write,
// combinational read of the supplied address.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational)
module uart_frame_buf #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_framer.sv
// UART receive framer. Reassembles [A5][LEN][payload x LEN][CSUM] frames from
// the UART receiver strobes, buffers the payload, and releases it on a
// valid/ready stream only once the checksum (LEN + payload + CSUM == 0 mod 256)
// passes. Bad frames are discarded whole and reported with a reason code.
// Optional build macro UART_FRAMER_STATS_EN adds saturating good/bad frame
// counters stat_ok / stat_err.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   received, rx_byte   byte strobe and data from the UART receiver
//   recv_error          UART framing error strobe
//   out_valid/ready     payload stream handshake
//   out_data, out_last  payload byte, final-byte marker
//   frame_ok            pulse: good frame accepted
//   frame_err, err_code pulse: frame discarded, with reason
//   overrun             pulse: byte dropped while draining
//   stat_ok, stat_err   frame counters (UART_FRAMER_STATS_EN only)
module uart_rx_framer
    import uart_framer_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 32,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        recv_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        overrun
`ifdef UART_FRAMER_STATS_EN
    ,
    output logic [15:0] stat_ok,
    output logic [15:0] stat_err
`endif
);

    localparam int unsigned PTR_W  = $clog2(MAX_LEN + 1);
    localparam int unsigned ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [PTR_W-1:0] len_q, len_d;
    logic [7:0]       sum_q, sum_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    out_beat_t        beat_q, beat_d;
    logic             valid_q, valid_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             ovr_q, ovr_d;

    logic             buf_we_c;
    logic [PTR_W-1:0] rd_addr_c;
    logic [7:0]       rd_data_c;
    logic [7:0]       sum_next_c;
    logic             advance_c;

    // Payload storage.
    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we_c),
        .waddr (ADDR_W'(wr_ptr_q)),
        .wdata (rx_byte),
        .raddr (ADDR_W'(rd_addr_c)),
        .rdata (rd_data_c)
    );

    assign sum_next_c = csum_add(sum_q, rx_byte);

    // Read address leads the presented beat so the next byte is ready on handshake.
    assign advance_c = (state_q == ST_DRAIN) && valid_q && out_ready && !beat_q.last;
    assign rd_addr_c = advance_c ? PTR_W'(rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            len_q    <= '0;
            sum_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            to_cnt_q <= '0;
            beat_q   <= '0;
            valid_q  <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            sum_q    <= sum_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            to_cnt_q <= to_cnt_d;
            beat_q   <= beat_d;
            valid_q  <= valid_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            code_q   <= code_d;
            ovr_q    <= ovr_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        sum_d    = sum_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        to_cnt_d = '0;
        beat_d   = beat_q;
        valid_d  = valid_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
        ovr_d    = 1'b0;
        buf_we_c = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (received && rx_byte == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end

            ST_LEN, ST_PAYLOAD, ST_CSUM: begin
                // UART error beats timeout; a received byte restarts the idle timer.
                if (recv_error) begin
                    err_d   = 1'b1;
                    code_d  = ERR_UART;
                    state_d = ST_HUNT;
                end else if (received) begin
                    if (state_q == ST_LEN) begin
                        if (rx_byte == 8'h00 || rx_byte > MAX_LEN_B) begin
                            err_d   = 1'b1;
                            code_d  = ERR_LEN;
                            state_d = ST_HUNT;
                        end else begin
                            len_d    = PTR_W'(rx_byte);
                            sum_d    = rx_byte;
                            wr_ptr_d = '0;
                            state_d  = ST_PAYLOAD;
                        end
                    end else if (state_q == ST_PAYLOAD) begin
                        buf_we_c = 1'b1;
                        sum_d    = sum_next_c;
                        wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
                        if (wr_ptr_q == PTR_W'(len_q - PTR_W'(1))) begin
                            state_d = ST_CSUM;
                        end
                    end else begin
                        if (sum_next_c == 8'h00) begin
                            ok_d     = 1'b1;
                            rd_ptr_d = '0;
                            state_d  = ST_DRAIN;
                        end else begin
                            err_d   = 1'b1;
                            code_d  = ERR_CSUM;
                            state_d = ST_HUNT;
                        end
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = ST_HUNT;
                end else begin
                    to_cnt_d = TO_W'(to_cnt_q + TO_W'(1));
                end
            end

            ST_DRAIN: begin
                ovr_d = received;
                if (!valid_q) begin
                    // First beat after the checksum passed.
                    valid_d = 1'b1;
                    beat_d  = '{data: rd_data_c, last: (rd_ptr_q == PTR_W'(len_q - PTR_W'(1)))};
                end else if (out_ready) begin
                    if (beat_q.last) begin
                        valid_d = 1'b0;
                        state_d = ST_HUNT;
                    end else begin
                        rd_ptr_d = rd_addr_c;
                        beat_d   = '{data: rd_data_c, last: (rd_addr_c == PTR_W'(len_q - PTR_W'(1)))};
                    end
                end
            end

            default: begin
                state_d = ST_HUNT;
                valid_d = 1'b0;
            end
        endcase
    end

    assign out_valid = valid_q;
    assign out_data  = beat_q.data;
    assign out_last  = beat_q.last;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign err_code  = code_q;
    assign overrun   = ovr_q;

`ifdef UART_FRAMER_STATS_EN
    logic [15:0] stat_ok_q;
    logic [15:0] stat_err_q;

    // Saturating frame counters driven by the registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ok_q  <= '0;
            stat_err_q <= '0;
        end else begin
            if (ok_q && stat_ok_q != 16'hFFFF) begin
                stat_ok_q <= 16'(stat_ok_q + 16'd1);
            end
            if (err_q && stat_err_q != 16'hFFFF) begin
                stat_err_q <= 16'(stat_err_q + 16'd1);
            end
        end
    end

    assign stat_ok  = stat_ok_q;
    assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: stimulus pushes expected beats and
// frame events into queues; a negedge monitor pops and compares them.
module tb_uart_rx_framer;

    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned TMO     = 100;
    localparam int EV_OK  = 4;
    localparam int EV_OVR = 5;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;
    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       received = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       recv_error = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       overrun;
`ifdef UART_FRAMER_STATS_EN
    logic [15:0] stat_ok;
    logic [15:0] stat_err;
`endif

    uart_rx_framer #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .received   (received),
        .rx_byte    (rx_byte),
        .recv_error (recv_error),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .overrun    (overrun)
`ifdef UART_FRAMER_STATS_EN
        ,
        .stat_ok    (stat_ok),
        .stat_err   (stat_err)
`endif
    );

    always #5 clk = ~clk;

    int    vectors     = 0;
    int    miscompares = 0;
    beat_t data_q[$];
    int    ev_q[$];
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_event(input string name, input int got);
        int e;
        if (ev_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got event %0d, expected none (t=%0t)", name, got, $time);
        end else begin
            e = ev_q.pop_front();
            check(name, 32'(got), 32'(e));
        end
    endtask

    // Monitor: compares stream beats, stall stability and event pulses.
    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(stall_data));
            end
            if (out_valid && out_ready) begin
                if (data_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat: got %0h, expected no output (t=%0t)", out_data, $time);
                end else begin
                    b = data_q.pop_front();
                    check("beat_data", 32'(out_data), 32'(b.data));
                    check("beat_last", 32'(out_last), 32'(b.last));
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (frame_ok)  expect_event("frame_ok", EV_OK);
            if (frame_err) expect_event("frame_err", int'(err_code));
            if (overrun)   expect_event("overrun", EV_OVR);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        received = 1'b1;
        rx_byte  = b;
        tick();
        received = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_seq(input byte_q_t s);
        foreach (s[i]) send(s[i]);
    endtask

    task automatic push_beat(input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        data_q.push_back(b);
    endtask

    // Builds a valid frame around the payload and queues its expectations.
    task automatic good_frame(input byte_q_t pl);
        logic [7:0] s;
        s = 8'(pl.size());
        ev_q.push_back(EV_OK);
        foreach (pl[i]) begin
            push_beat(pl[i], i == pl.size() - 1);
            s = 8'(s + pl[i]);
        end
        send(8'hA5);
        send(8'(pl.size()));
        send_seq(pl);
        send(8'(8'h00 - s));
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((data_q.size() != 0 || ev_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 32'(data_q.size() + ev_q.size()), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_frame_ok"},  32'(frame_ok),  32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_err_code"},  32'(err_code),  32'd0);
        check({tag, "_overrun"},   32'(overrun),   32'd0);
`ifdef UART_FRAMER_STATS_EN
        check({tag, "_stat_ok"},   32'(stat_ok),   32'd0);
        check({tag, "_stat_err"},  32'(stat_err),  32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte_q_t pl;
        int n;

        rst = 1'b1;
        repeat (3) tick();
        check_idle("reset");
        rst = 1'b0;
        tick();

        // Three-byte frame: 03+11+22+33 = 0x69, checksum 0x97.
        out_ready = 1'b1;
        push_beat(8'h11, 1'b0);
        push_beat(8'h22, 1'b0);
        push_beat(8'h33, 1'b1);
        ev_q.push_back(EV_OK);
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97});
        wait_drain(50);

        // Same frame with 0x9F: sum is 0x08, discarded as checksum error.
        ev_q.push_back(0);
        send_seq('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9F});
        wait_drain(20);

        // Bad checksum then good frame (02+10+20 = 0x32, checksum 0xCE).
        ev_q.push_back(0);
        send_seq('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00});
        push_beat(8'h10, 1'b0);
        push_beat(8'h20, 1'b1);
        ev_q.push_back(EV_OK);
        send_seq('{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE});
        wait_drain(50);

        // Length errors: zero and MAX_LEN+1.
        ev_q.push_back(1);
        send_seq('{8'hA5, 8'h00});
        ev_q.push_back(1);
        send_seq('{8'hA5, 8'h21});
        wait_drain(20);

        // Noise in HUNT is ignored, including a UART error strobe.
        send_seq('{8'h00, 8'h5A, 8'h21});
        recv_error = 1'b1;
        tick();
        recv_error = 1'b0;
        tick();

        // One-byte payload equal to the sync byte: 01+A5 = 0xA6, checksum 0x5A.
        push_beat(8'hA5, 1'b1);
        ev_q.push_back(EV_OK);
        send_seq('{8'hA5, 8'h01, 8'hA5, 8'h5A});
        wait_drain(50);

        // Maximum-length frame.
        pl = {};
        for (int i = 0; i < int'(MAX_LEN); i++) pl.push_back(8'(i * 7 + 8'hA0));
        good_frame(pl);
        wait_drain(100);

        // Inter-byte timeout, then UART error mid-frame.
        ev_q.push_back(2);
        send_seq('{8'hA5, 8'h02, 8'h10});
        repeat (TMO + 20) tick();
        wait_drain(20);
        ev_q.push_back(3);
        send_seq('{8'hA5, 8'h02});
        recv_error = 1'b1;
        tick();
        recv_error = 1'b0;
        tick();
        wait_drain(20);

        // Backpressure with random ready and an overrun byte during drain.
        // 04+01+02+03+04 = 0x0E, checksum 0xF2.
        out_ready = 1'b0;
        push_beat(8'h01, 1'b0);
        push_beat(8'h02, 1'b0);
        push_beat(8'h03, 1'b0);
        push_beat(8'h04, 1'b1);
        ev_q.push_back(EV_OK);
        send_seq('{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2});
        ev_q.push_back(EV_OVR);
        send(8'h55);
        n = 0;
        while (data_q.size() != 0 && n < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        wait_drain(50);

        // Reset mid-payload discards the partial frame.
        send_seq('{8'hA5, 8'h04, 8'h01, 8'h02});
        rst = 1'b1;
        tick();
        check_idle("rst_payload");
        rst = 1'b0;
        tick();
        good_frame('{8'h3C, 8'hC3});
        wait_drain(50);

        // Reset mid-drain discards the buffered payload.
        out_ready = 1'b0;
        good_frame('{8'h01, 8'h02, 8'h03});
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("drain_reached", 32'(out_valid), 32'd1);
        rst = 1'b1;
        data_q.delete();
        tick();
        check_idle("rst_drain");
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        good_frame('{8'hDE, 8'hAD, 8'hBE, 8'hEF});
        wait_drain(50);

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
